// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array.
// One synchronous write port and one asynchronous read port. The array is
// deliberately not reset; the pointers define which entries are valid.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, flush and optional first-word-fall-through.
module fifo_sync_ext
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_wrEn,
  input  logic [WIDTH-1:0]           fifo_wrData,
  input  logic                       fifo_rdEn,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           fifo_rdData,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       fifo_almost_empty,
  output logic                       fifo_almost_full,
  output logic [cnt_w(DEPTH)-1:0]    data_count,
  output logic                       fifo_overflow,
  output logic                       fifo_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Status flags are pure decodes of the registered occupancy.
  assign fifo_empty        = (count_q == '0);
  assign fifo_full         = (count_q == FULL_CNT);
  assign fifo_almost_empty = (count_q <= AE_CNT);
  assign fifo_almost_full  = (count_q >= AF_CNT);
  assign data_count        = count_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

  // Flush takes priority over both requests; full blocks writes and empty
  // blocks reads, so a simultaneous pair at a boundary keeps only the legal one.
  assign wr_acc = fifo_wrEn & ~fifo_full  & ~flush;
  assign rd_acc = fifo_rdEn & ~fifo_empty & ~flush;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (fifo_wrData),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  // FWFT shows the head word directly (zero when empty); standard mode
  // shows the word captured by the last accepted read.
  assign fifo_rdData = (FWFT != 0) ? (fifo_empty ? '0 : mem_rdata) : rd_data_q;

  // Next-state for pointers, occupancy, read register and sticky errors.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps DEPTH-1 -> 0.
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~clr_err) | (fifo_wrEn & fifo_full  & ~flush);
    udf_d = (udf_q & ~clr_err) | (fifo_rdEn & fifo_empty & ~flush);
  end

  // Control and read-data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Bench for fifo_sync_ext: a standard-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_fifo_sync_ext;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr = 1'b0, rd = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] rdata0, rdata1;
  logic         empty0, full0, ae0, af0, ovf0, udf0;
  logic         empty1, full1, ae1, af1, ovf1, udf1;
  logic [3:0]   cnt0, cnt1;

  fifo_sync_ext #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .fifo_wrEn(wr), .fifo_wrData(din),
    .fifo_rdEn(rd), .flush(flush), .clr_err(clr), .fifo_rdData(rdata0),
    .fifo_empty(empty0), .fifo_full(full0), .fifo_almost_empty(ae0),
    .fifo_almost_full(af0), .data_count(cnt0), .fifo_overflow(ovf0),
    .fifo_underflow(udf0)
  );

  fifo_sync_ext #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_wrEn(wr), .fifo_wrData(din),
    .fifo_rdEn(rd), .flush(flush), .clr_err(clr), .fifo_rdData(rdata1),
    .fifo_empty(empty1), .fifo_full(full1), .fifo_almost_empty(ae1),
    .fifo_almost_full(af1), .data_count(cnt1), .fifo_overflow(ovf1),
    .fifo_underflow(udf1)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, errors and registered read word.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf;
  logic [W-1:0] m_rd;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit           wr, rd, fl, clr;
    logic [W-1:0] din;
    int           cnt;
    bit           full, empty, af, ovf, udf;
    logic [W-1:0] rd0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, bit r, bit f, bit c, logic [W-1:0] d,
                              int n, bit fu, bit em, bit a, bit o, bit u,
                              logic [W-1:0] q);
    vec_t v;
    v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.din = d;
    v.cnt = n; v.full = fu; v.empty = em; v.af = a; v.ovf = o; v.udf = u;
    v.rd0 = q;
    return v;
  endfunction

  task automatic check(string nm, longint unsigned act, longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rd  = '0;
  endtask

  task automatic model_edge();
    bit is_full  = (mq.size() == D);
    bit is_empty = (mq.size() == 0);
    bit wok = wr && !is_full && !flush;
    bit rok = rd && !is_empty && !flush;
    m_ovf = (m_ovf && !clr) || (wr && is_full && !flush);
    m_udf = (m_udf && !clr) || (rd && is_empty && !flush);
    if (flush) mq.delete();
    else begin
      if (rok) m_rd = mq.pop_front();
      if (wok) mq.push_back(din);
    end
  endtask

  task automatic check_all();
    int n = mq.size();
    check("count0", cnt0, n);
    check("count1", cnt1, n);
    check("empty0", empty0, n == 0);
    check("empty1", empty1, n == 0);
    check("full0", full0, n == D);
    check("full1", full1, n == D);
    check("ae0", ae0, n <= 2);
    check("ae1", ae1, n <= 2);
    check("af0", af0, n >= D - 2);
    check("af1", af1, n >= D - 2);
    check("ovf0", ovf0, m_ovf);
    check("ovf1", ovf1, m_ovf);
    check("udf0", udf0, m_udf);
    check("udf1", udf1, m_udf);
    check("rdata0", rdata0, m_rd);
    check("rdata1", rdata1, (n > 0) ? mq[0] : 0);
  endtask

  task automatic step(bit w, bit r, bit f, bit c, logic [W-1:0] d);
    wr = w; rd = r; flush = f; clr = c; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: fill, overflow, clear, drain, underflow, clear.
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, 0, 0, 0, W'(i), i, i == 8, 0, i >= 6, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'hAA, 8, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8, 1, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8 - k, 0, k == 8, (8 - k) >= 6, 0, 0, W'(k)));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h08));
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 0, 1, 8'h08));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 8'h08));

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_empty", empty0, 1);
    check("rst_ae", ae0, 1);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].din);
      check($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].cnt);
      check($sformatf("tbl%0d_full", i), full0, tbl[i].full);
      check($sformatf("tbl%0d_empty", i), empty0, tbl[i].empty);
      check($sformatf("tbl%0d_af", i), af0, tbl[i].af);
      check($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ovf);
      check($sformatf("tbl%0d_udf", i), udf0, tbl[i].udf);
      check($sformatf("tbl%0d_rd", i), rdata0, tbl[i].rd0);
    end

    // Steady occupancy of 4 with simultaneous traffic: pointers wrap.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, W'(8'h10 + i));
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 0, W'(8'h14 + k));
      check("wrap_cnt", cnt0, 4);
      check("wrap_rd", rdata0, 8'h10 + k);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    check("wrap_drain_empty", empty0, 1);

    // FWFT: write to empty shows the word without a read.
    step(1, 0, 0, 0, 8'h5A);
    check("fwft_rd", rdata1, 8'h5A);
    check("fwft_nempty", empty1, 0);
    step(0, 0, 0, 0, 8'h00);
    check("fwft_hold", rdata1, 8'h5A);
    step(0, 1, 0, 0, 8'h00);
    check("fwft_pop_rd", rdata1, 8'h00);
    check("fwft_pop_empty", empty1, 1);

    // Flush with a concurrent write: contents and write both discarded.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'(8'h20 + i));
    check("pre_flush_cnt", cnt0, 5);
    step(1, 0, 1, 0, 8'h77);
    check("flush_cnt", cnt0, 0);
    check("flush_empty", empty0, 1);
    check("flush_rd_hold", rdata0, 8'h5A);
    step(1, 0, 0, 0, 8'h33);
    step(0, 1, 0, 0, 8'h00);
    check("post_flush_rd", rdata0, 8'h33);
    step(0, 1, 0, 0, 8'h00);
    check("post_flush_udf", udf0, 1);

    // Reset asserted mid-burst acts immediately, without a clock edge.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, W'(8'h40 + i));
    wr = 1; din = 8'h44;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_cnt", cnt0, 0);
    check("arst_rd0", rdata0, 0);
    check("arst_udf", udf0, 0);
    check("arst_af", af1, 0);
    wr = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized traffic: write-heavy half, then read-heavy half.
    for (int i = 0; i < 600; i++) begin
      bit w, r, f, c;
      w = (i < 300) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 35);
      r = (i < 300) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 65);
      f = ($urandom_range(99) < 2);
      c = ($urandom_range(99) < 5);
      step(w, r, f, c, W'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ext.md
FIFO_SYNC_EXT -- requirements
Module: fifo_sync_ext

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal 1..64.
REQ-002 Parameter DEPTH, default 8: entries, power of two, legal 4..1024.
REQ-003 Parameter FWFT, default 0: read mode, 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold, legal 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 2: almost-empty threshold, legal 0..DEPTH-1.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port fifo_wrEn, input, 1: write request.
REQ-009 Port fifo_wrData, input, WIDTH: write data.
REQ-010 Port fifo_rdEn, input, 1: read request (pop in FWFT mode).
REQ-011 Port flush, input, 1: synchronous discard of all contents.
REQ-012 Port clr_err, input, 1: synchronous clear of sticky error flags.
REQ-013 Port fifo_rdData, output, WIDTH: read data.
REQ-014 Port fifo_empty and fifo_full, outputs, 1 each: occupancy == 0 and occupancy == DEPTH.
REQ-015 Port fifo_almost_empty and fifo_almost_full, outputs, 1 each: occupancy <= AE_LEVEL and occupancy >= AF_LEVEL.
REQ-016 Port data_count, output, $clog2(DEPTH)+1: current occupancy 0..DEPTH.
REQ-017 Port fifo_overflow and fifo_underflow, outputs, 1 each: sticky error flags.

Function
REQ-018 The FIFO SHALL accept a write iff fifo_wrEn=1, fifo_full=0 and flush=0, storing fifo_wrData at wr_ptr.
REQ-019 The FIFO SHALL accept a read iff fifo_rdEn=1, fifo_empty=0 and flush=0.
REQ-020 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits, advance by 1 per accepted operation, and wrap DEPTH-1 -> 0.
REQ-021 data_count SHALL be registered: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-022 Simultaneous wrEn and rdEn while full SHALL accept only the read; while empty, only the write.
REQ-023 All four status flags SHALL be decoded from registered data_count and change in the same cycle data_count changes.
REQ-024 FWFT=0: an accepted read SHALL load the head word into fifo_rdData on that clock edge (valid one cycle after rdEn); otherwise fifo_rdData holds its value.
REQ-025 FWFT=1: fifo_rdData SHALL present the head word combinationally whenever fifo_empty=0 and 0 when empty; an accepted read advances to the next word.
REQ-026 A write to an empty FIFO SHALL deassert fifo_empty on the edge that accepts the write (FWFT data visible the following cycle).
REQ-027 fifo_wrEn=1 while fifo_full=1 SHALL set fifo_overflow on that edge; data dropped, state unchanged.
REQ-028 fifo_rdEn=1 while fifo_empty=1 SHALL set fifo_underflow on that edge; fifo_rdData unchanged.
REQ-029 clr_err=1 SHALL clear both error flags on the next edge; a new error in the same cycle wins (flag stays set).
REQ-030 flush=1 SHALL zero pointers and data_count on the next edge, ignore wr/rd requests that cycle, and leave error flags and fifo_rdData (FWFT=0) unchanged.

Reset
REQ-031 reset=0 SHALL asynchronously force: pointers 0, data_count 0, fifo_empty 1, fifo_full 0, fifo_almost_empty 1, fifo_almost_full 0, fifo_rdData 0, both error flags 0.
REQ-032 Storage array SHALL NOT be reset; reset asserted mid-operation discards all contents.

Structure
REQ-033 Package fifo_pkg SHALL hold default WIDTH/DEPTH constants and the count-width function; no typedefs elsewhere.
REQ-034 Storage SHALL be sub-module fifo_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
REQ-035 Pointer, count, flag and error logic SHALL live in fifo_sync_ext; target 150-300 RTL lines.

Verification
REQ-036 Reset, write 0x01..0x08 (DEPTH=8) -> data_count 8, fifo_full=1, almost_full from count 6; read all -> 0x01..0x08 in order, fifo_empty=1.
REQ-037 Full FIFO, wrEn=1 with 0xAA -> fifo_overflow=1, count stays 8, 0xAA never read; clr_err -> flag 0.
REQ-038 Empty FIFO, rdEn=1 -> fifo_underflow=1, count 0; simultaneous clr_err and rdEn -> flag remains 1.
REQ-039 Count 4, wrEn and rdEn together for 20 cycles with incrementing data -> count constant 4, ptr wrap verified, order preserved.
REQ-040 FWFT=1: write 0x5A to empty -> fifo_rdData=0x5A the next cycle without rdEn; rdEn -> fifo_rdData=0, empty=1.
REQ-041 Count 5, flush=1 with wrEn -> count 0, empty=1, write dropped; reset=0 asserted mid-burst -> all outputs at REQ-031 values immediately.
